// File: rtl/meter_update_arbiter.sv
// Parking-meter time register sequencer: queues coin, preset and 1 Hz tick requests
// and applies at most one update per clock to the saturating count.
module meter_update_arbiter #(
  parameter logic [15:0] MAX_COUNT = 16'd9999,
  parameter logic [15:0] ADD0      = 16'd10,
  parameter logic [15:0] ADD1      = 16'd180,
  parameter logic [15:0] ADD2      = 16'd200,
  parameter logic [15:0] ADD3      = 16'd550,
  parameter logic [15:0] PRESET0   = 16'd10,
  parameter logic [15:0] PRESET1   = 16'd205
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  coin_req_i,
  input  logic [1:0]  preset_req_i,
  input  logic        tick_i,
  output logic [15:0] count_o,
  output logic        busy_o,
  output logic        drop_o,
  output logic        expired_o
);

  logic [3:0][1:0] pend_q, pend_d;
  logic            tick_q, tick_d;
  logic [1:0]      rr_q, rr_d;
  logic [15:0]     count_q, count_d;
  logic            drop_q, drop_d;
  logic            expired_q;

  logic [3:0]      grant;
  logic            found;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic [15:0]     add_val;
  logic [16:0]     sum;
  logic            tick_srv;

  // Round-robin search: first source with pending coins at or after rr_q.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && (pend_q[idx] != 2'd0)) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    add_val = ADD0;
      2'd1:    add_val = ADD1;
      2'd2:    add_val = ADD2;
      default: add_val = ADD3;
    endcase
    sum = {1'b0, count_q} + {1'b0, add_val};
  end

  always_comb begin
    pend_d   = pend_q;
    tick_d   = tick_q;
    rr_d     = rr_q;
    count_d  = count_q;
    drop_d   = 1'b0;
    grant    = 4'b0000;
    tick_srv = 1'b0;

    if (preset_req_i != 2'b00) begin
      // Preset wipes the queue; same-cycle requests vanish without a drop.
      count_d = preset_req_i[0] ? PRESET0 : PRESET1;
      pend_d  = '0;
      tick_d  = 1'b0;
    end else begin
      if (found) begin
        grant[win] = 1'b1;
        count_d    = (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[15:0];
        rr_d       = win + 2'd1;
      end else if (tick_q) begin
        tick_srv = 1'b1;
        count_d  = (count_q != 16'd0) ? count_q - 16'd1 : count_q;
      end

      for (int i = 0; i < 4; i++) begin
        case ({coin_req_i[i], grant[i]})
          2'b10: begin
            if (pend_q[i] == 2'd3) drop_d = 1'b1;
            else                   pend_d[i] = pend_q[i] + 2'd1;
          end
          2'b01:   pend_d[i] = pend_q[i] - 2'd1;
          default: pend_d[i] = pend_q[i];
        endcase
      end

      if (tick_i) begin
        if (tick_q && !tick_srv) drop_d = 1'b1;
        tick_d = 1'b1;
      end else if (tick_srv) begin
        tick_d = 1'b0;
      end

      if (count_q > MAX_COUNT) count_d = MAX_COUNT;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q    <= '0;
      tick_q    <= 1'b0;
      rr_q      <= 2'd0;
      count_q   <= 16'd0;
      drop_q    <= 1'b0;
      expired_q <= 1'b1;
    end else begin
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      rr_q      <= rr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      expired_q <= (count_d == 16'd0);
    end
  end

  assign count_o   = count_q;
  assign busy_o    = (|pend_q) | tick_q;
  assign drop_o    = drop_q;
  assign expired_o = expired_q;

endmodule
